// File: rtl/counter_9999_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_9999_ctrl_pkg
// Purpose  : Shared command encodings, FSM state type and BCD helpers for the
//            4-digit BCD counter controller.
// Revision : 1.0 - initial release
// ============================================================================
package counter_9999_ctrl_pkg;

  // Command opcodes carried on cmd_op; all other codes are reserved (no-op)
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_START = 3'b010;
  localparam logic [2:0] OP_STOP  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // True when every nibble of a 4-digit BCD word is a decimal digit
  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0]   <= 4'd9) && (v[7:4]   <= 4'd9) &&
           (v[11:8]  <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  // 4-digit BCD increment, 9999 wraps to 0000 like the external counter
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_9999_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : counter_9999_ctrl_prescaler
// Purpose  : Free-running 0..limit divider; tick is high in the cycle where
//            the count equals limit, after which the count wraps to zero.
// Revision : 1.0 - initial release
// ============================================================================
module counter_9999_ctrl_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] limit,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] count;

  // >= guards against a count stranded above a limit that was lowered
  assign tick = enable && !clear && (count >= limit);

  // Count while enabled, wrap on tick, hold at zero while cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/counter_9999_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_9999_ctrl
// Purpose  : Command-driven controller for an external 4-digit BCD counter:
//            load, start/stop ticking at a prescaled rate, stop at a target
//            value with a done interrupt, sticky error on malformed BCD.
// Revision : 1.0 - initial release
// ============================================================================
module counter_9999_ctrl
  import counter_9999_ctrl_pkg::*;
#(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [15:0]           cmd_data,
  input  logic [15:0]           target,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [15:0]           cnt_value,
  output logic                  cnt_reset,
  output logic                  cnt_load,
  output logic [15:0]           cnt_load_value,
  output logic                  cnt_enable,
  output logic                  busy,
  output logic                  done_irq,
  output logic                  err
);

  state_t                state;
  state_t                state_next;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [15:0]           target_q;
  logic [15:0]           cnt_view;
  logic                  accept;
  logic                  do_load;
  logic                  do_start;
  logic                  do_clear;
  logic                  set_err;
  logic                  hit;
  logic                  enable_next;
  logic                  tick;
  logic                  pre_clear;
  logic                  pre_enable;

  assign accept     = cmd_valid && cmd_ready;
  assign pre_enable = (state == ST_RUN);
  assign pre_clear  = (state != ST_RUN);

  counter_9999_ctrl_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .enable  (pre_enable),
    .limit   (prescale_q),
    .tick    (tick)
  );

  // Command decode, sequencing and the run-time match/tick decision
  always_comb begin
    state_next  = state;
    do_load     = 1'b0;
    do_start    = 1'b0;
    do_clear    = 1'b0;
    set_err     = 1'b0;
    hit         = 1'b0;
    enable_next = 1'b0;
    // cnt_enable is registered, so a tick issued last cycle lands at the end
    // of this one; compare against the value the counter is about to hold so
    // a back-to-back tick (prescale 0) never overshoots the target.
    cnt_view    = cnt_enable ? bcd_inc(cnt_value) : cnt_value;

    case (state)
      ST_LOAD:   state_next = ST_SETTLE;
      ST_SETTLE: state_next = ST_IDLE;
      default: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD: begin
              if (bcd_valid(cmd_data)) begin
                do_load    = 1'b1;
                state_next = ST_LOAD;
              end else begin
                set_err = 1'b1;
              end
            end
            OP_START: begin
              if (state != ST_RUN) begin
                if (bcd_valid(target)) begin
                  do_start   = 1'b1;
                  state_next = ST_RUN;
                end else begin
                  set_err = 1'b1;
                end
              end
            end
            OP_STOP: begin
              if (state == ST_RUN) begin
                state_next = ST_IDLE;
              end
            end
            OP_CLEAR: begin
              do_clear   = 1'b1;
              state_next = ST_IDLE;
            end
            default: ;
          endcase
        end
      end
    endcase

    // Only an undisturbed RUN cycle checks for match (before ticking)
    if (state == ST_RUN && state_next == ST_RUN) begin
      if (cnt_view == target_q) begin
        hit        = 1'b1;
        state_next = ST_DONE;
      end else begin
        enable_next = tick;
      end
    end
  end

  // FSM state and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      prescale_q     <= '0;
      target_q       <= '0;
      cmd_ready      <= 1'b0;
      cnt_reset      <= 1'b1;
      cnt_load       <= 1'b0;
      cnt_load_value <= '0;
      cnt_enable     <= 1'b0;
      busy           <= 1'b0;
      done_irq       <= 1'b0;
      err            <= 1'b0;
    end else begin
      state      <= state_next;
      cmd_ready  <= (state_next == ST_IDLE) || (state_next == ST_RUN) ||
                    (state_next == ST_DONE);
      busy       <= (state_next == ST_LOAD) || (state_next == ST_SETTLE) ||
                    (state_next == ST_RUN);
      cnt_reset  <= do_clear;
      cnt_load   <= do_load;
      cnt_enable <= enable_next;
      done_irq   <= hit;
      if (do_load) begin
        cnt_load_value <= cmd_data;
      end
      if (do_start) begin
        prescale_q <= prescale;
        target_q   <= target;
      end
      if (do_clear) begin
        err <= 1'b0;
      end else if (set_err) begin
        err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_9999_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_9999_ctrl
// Purpose  : Self-checking bench for counter_9999_ctrl with a behavioural
//            BCD counter attached and randomized scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_9999_ctrl;

  localparam int PW = 16;
  localparam logic [2:0] T_NOP = 3'd0, T_LOAD = 3'd1, T_START = 3'd2, T_STOP = 3'd3, T_CLEAR = 3'd4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = T_NOP;
  logic [15:0]   cmd_data = '0;
  logic [15:0]   target = '0;
  logic [PW-1:0] prescale = '0;
  logic [15:0]   cnt_value;
  logic          cnt_reset, cnt_load, cnt_enable, busy, done_irq, err;
  logic [15:0]   cnt_load_value;

  int   ctr = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic exp_err = 1'b0;
  logic [15:0] exp_lv = '0;

  always #5 clk = ~clk;

  counter_9999_ctrl #(.PRESCALE_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .target(target), .prescale(prescale),
    .cnt_value(cnt_value), .cnt_reset(cnt_reset), .cnt_load(cnt_load),
    .cnt_load_value(cnt_load_value), .cnt_enable(cnt_enable), .busy(busy),
    .done_irq(done_irq), .err(err)
  );

  function automatic logic [15:0] to_bcd(input int d);
    logic [15:0] r;
    r[15:12] = 4'((d / 1000) % 10);
    r[11:8]  = 4'((d / 100) % 10);
    r[7:4]   = 4'((d / 10) % 10);
    r[3:0]   = 4'(d % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic nibbles_ok(input logic [15:0] v);
    int x;
    x = int'(v);
    for (int i = 0; i < 4; i++) if (((x >> (4 * i)) & 15) > 9) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural 4-digit decimal counter driven by the controller
  always @(posedge clk) begin
    if (cnt_reset)       ctr <= 0;
    else if (cnt_load)   ctr <= from_bcd(cnt_load_value);
    else if (cnt_enable) ctr <= (ctr + 1) % 10000;
  end
  assign cnt_value = to_bcd(ctr);

  task automatic tick_edge();
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [15:0] data);
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    tick_edge();
    cmd_valid = 1'b0; cmd_op = T_NOP;
  endtask

  task automatic do_load(input logic [15:0] v);
    send_cmd(T_LOAD, v);
    repeat (2) tick_edge();
    exp_lv = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cnt_reset !== 1'b1) begin n_fail++; $display("FAIL reset_cnt_reset: got %b want 1", cnt_reset); end
    n_checks++; if (cnt_load !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_load: got %b want 0", cnt_load); end
    n_checks++; if (cnt_enable !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_enable: got %b want 0", cnt_enable); end
    n_checks++; if (cnt_load_value !== 16'h0) begin n_fail++; $display("FAIL reset_load_value: got %h want 0000", cnt_load_value); end
    n_checks++; if (done_irq !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got done=%b err=%b busy=%b want 0 0 0", done_irq, err, busy); end
    reset_n = 1'b1;
    tick_edge();
    n_checks++; if (cnt_reset !== 1'b0) begin n_fail++; $display("FAIL release_cnt_reset: got %b want 0", cnt_reset); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); end
    exp_err = 1'b0; exp_lv = '0;
  endtask

  task automatic test_load_valid();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      v = (k == 0) ? 16'h1234 : to_bcd(int'($urandom_range(0, 9999)));
      send_cmd(T_LOAD, v);
      exp_lv = v;
      n_checks++; if (cnt_load !== 1'b1 || cnt_load_value !== v) begin n_fail++; $display("FAIL load_strobe: got load=%b val=%h want 1 %h", cnt_load, cnt_load_value, v); end
      n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_state: got ready=%b busy=%b want 0 1", cmd_ready, busy); end
      tick_edge();
      n_checks++; if (cnt_load !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL settle_state: got load=%b ready=%b want 0 0", cnt_load, cmd_ready); end
      tick_edge();
      n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || cnt_value !== v) begin n_fail++; $display("FAIL load_idle: got ready=%b busy=%b cnt=%h want 1 0 %h", cmd_ready, busy, cnt_value, v); end
    end
  endtask

  task automatic test_load_invalid();
    logic [15:0] v;
    logic        ok;
    for (int k = 0; k < 6; k++) begin
      v  = (k == 0) ? 16'h12A4 : 16'($urandom);
      ok = nibbles_ok(v);
      send_cmd(T_LOAD, v);
      if (ok) exp_lv = v; else exp_err = 1'b1;
      n_checks++; if (cnt_load !== ok || err !== exp_err || cnt_load_value !== exp_lv) begin n_fail++; $display("FAIL load_check %h: got load=%b err=%b val=%h want %b %b %h", v, cnt_load, err, cnt_load_value, ok, exp_err, exp_lv); end
      if (!ok) begin
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bad_load_state: got ready=%b busy=%b want 1 0", cmd_ready, busy); end
      end else begin
        repeat (2) tick_edge();
      end
    end
    send_cmd(T_CLEAR, 16'h0);
    exp_err = 1'b0;
    n_checks++; if (cnt_reset !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL clear_pulse: got rst=%b err=%b want 1 0", cnt_reset, err); end
    tick_edge();
    n_checks++; if (cnt_reset !== 1'b0 || cnt_value !== 16'h0) begin n_fail++; $display("FAIL clear_after: got rst=%b cnt=%h want 0 0000", cnt_reset, cnt_value); end
  endtask

  // START and observe: ticks every p+1 cycles, done after d ticks
  task automatic run_and_check(input int start_dec, input int target_dec, input int p);
    int d, exp_done, tick_cnt, tick_bad, done_cnt, done_at;
    d        = (target_dec - start_dec + 10000) % 10000;
    exp_done = d * (p + 1) + 1;
    prescale = PW'(p);
    target   = to_bcd(target_dec);
    send_cmd(T_START, 16'($urandom));
    prescale = PW'($urandom_range(0, 7));
    target   = to_bcd(int'($urandom_range(0, 9999)));
    tick_cnt = 0; tick_bad = 0; done_cnt = 0; done_at = -1;
    for (int t = 0; t <= exp_done + 4; t++) begin
      if (t > 0) tick_edge();
      if (cnt_enable) begin
        tick_cnt++;
        if ((t % (p + 1)) != 0 || t == 0 || t > d * (p + 1)) tick_bad++;
      end
      if (done_irq) begin done_cnt++; done_at = t; end
    end
    n_checks++; if (tick_cnt != d || tick_bad != 0) begin n_fail++; $display("FAIL run_ticks %0d->%0d p=%0d: got %0d (misplaced %0d) want %0d", start_dec, target_dec, p, tick_cnt, tick_bad, d); end
    n_checks++; if (done_cnt != 1 || done_at != exp_done) begin n_fail++; $display("FAIL run_done %0d->%0d p=%0d: got %0d pulses at %0d want 1 at %0d", start_dec, target_dec, p, done_cnt, done_at, exp_done); end
    n_checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || cnt_value !== to_bcd(target_dec)) begin n_fail++; $display("FAIL run_end: got busy=%b ready=%b cnt=%h want 0 1 %h", busy, cmd_ready, cnt_value, to_bcd(target_dec)); end
  endtask

  task automatic test_counting();
    int s, d, p;
    run_and_check(0, 3, 3);
    run_and_check(3, 3, int'($urandom_range(0, 4)));
    do_load(16'h9998);
    run_and_check(9998, 1, int'($urandom_range(0, 2)));
    for (int k = 0; k < 4; k++) begin
      s = int'($urandom_range(0, 9999));
      d = int'($urandom_range(0, 6));
      p = int'($urandom_range(0, 4));
      do_load(to_bcd(s));
      run_and_check(s, (s + d) % 10000, p);
    end
  endtask

  task automatic test_stop_resume();
    int p, w, ticks, idle_en;
    p = int'($urandom_range(1, 3));
    do_load(16'h0000);
    prescale = PW'(p);
    target   = 16'h0009;
    send_cmd(T_START, 16'h0);
    w = 2 * (p + 1) + 1;
    ticks = 0;
    for (int t = 1; t <= w; t++) begin
      tick_edge();
      if (cnt_enable) ticks++;
    end
    send_cmd(T_STOP, 16'h0);
    n_checks++; if (ticks != 2 || busy !== 1'b0 || cnt_enable !== 1'b0) begin n_fail++; $display("FAIL stop: got ticks=%0d busy=%b en=%b want 2 0 0", ticks, busy, cnt_enable); end
    idle_en = 0;
    for (int t = 0; t < 5; t++) begin
      tick_edge();
      if (cnt_enable) idle_en++;
    end
    n_checks++; if (idle_en != 0 || cnt_value !== 16'h0002) begin n_fail++; $display("FAIL stop_hold: got en=%0d cnt=%h want 0 0002", idle_en, cnt_value); end
    run_and_check(2, 9, p);
  endtask

  task automatic test_load_abort();
    int dn;
    do_load(16'h0000);
    prescale = '0;
    target   = 16'h0050;
    send_cmd(T_START, 16'h0);
    repeat (3) tick_edge();
    send_cmd(T_LOAD, 16'h0777);
    n_checks++; if (cnt_load !== 1'b1 || cnt_enable !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_load: got load=%b en=%b busy=%b want 1 0 1", cnt_load, cnt_enable, busy); end
    dn = (done_irq === 1'b1) ? 1 : 0;
    for (int t = 0; t < 6; t++) begin
      tick_edge();
      if (done_irq || cnt_enable) dn++;
    end
    n_checks++; if (dn != 0 || cnt_value !== 16'h0777 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_after: got stray=%0d cnt=%h busy=%b want 0 0777 0", dn, cnt_value, busy); end
  endtask

  task automatic test_clear_beats_match();
    int dn;
    prescale = PW'($urandom_range(0, 3));
    target   = cnt_value;
    send_cmd(T_START, 16'h0);
    send_cmd(T_CLEAR, 16'h0);
    n_checks++; if (cnt_reset !== 1'b1 || done_irq !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_match: got rst=%b done=%b busy=%b want 1 0 0", cnt_reset, done_irq, busy); end
    dn = 0;
    for (int t = 0; t < 4; t++) begin
      tick_edge();
      if (done_irq) dn++;
    end
    n_checks++; if (dn != 0 || cnt_value !== 16'h0) begin n_fail++; $display("FAIL clear_match_after: got done=%0d cnt=%h want 0 0000", dn, cnt_value); end
  endtask

  task automatic test_bad_target();
    int en;
    prescale = '0;
    target   = 16'h00A0;
    send_cmd(T_START, 16'h0);
    en = 0;
    for (int t = 0; t < 4; t++) begin
      tick_edge();
      if (cnt_enable) en++;
    end
    n_checks++; if (err !== 1'b1 || busy !== 1'b0 || en != 0) begin n_fail++; $display("FAIL bad_target: got err=%b busy=%b ticks=%0d want 1 0 0", err, busy, en); end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'h0000);
    prescale = PW'(2);
    target   = 16'h9000;
    send_cmd(T_START, 16'h0);
    repeat (5) tick_edge();
    n_checks++; if (busy !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL pre_reset: got busy=%b err=%b want 1 1", busy, err); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (cnt_reset !== 1'b1 || cnt_enable !== 1'b0 || cnt_load !== 1'b0) begin n_fail++; $display("FAIL midrun_reset: got rst=%b en=%b load=%b want 1 0 0", cnt_reset, cnt_enable, cnt_load); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0 || done_irq !== 1'b0 || cnt_load_value !== 16'h0) begin n_fail++; $display("FAIL midrun_flags: got busy=%b err=%b done=%b val=%h want 0 0 0 0000", busy, err, done_irq, cnt_load_value); end
    tick_edge();
    reset_n = 1'b1;
    tick_edge();
    n_checks++; if (cnt_reset !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun_release: got rst=%b ready=%b busy=%b want 0 1 0", cnt_reset, cmd_ready, busy); end
  endtask

  initial begin
    test_reset();
    test_load_valid();
    test_load_invalid();
    test_counting();
    test_stop_resume();
    test_load_abort();
    test_clear_beats_match();
    test_bad_target();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
